// File: rtl/rotor_stack_engine.sv
// rotor_stack_engine: N-rotor substitution engine with reflector and full double-step stepping.
// Define ROTOR_STACK_PLUGBOARD_EN to add a plugboard stage on input and output.
module rotor_stack_engine #(
  parameter int NUM_ROTORS = 3,
  parameter int ALPHA      = 26,
  parameter int W          = 5,
  parameter int SW         = 3,
  parameter int NOTCH_RST  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [NUM_ROTORS*W-1:0] pos_in,
  input  logic [NUM_ROTORS*W-1:0] ring_in,
  input  logic [NUM_ROTORS*W-1:0] notch_in,
  input  logic                  wire_we,
  input  logic [SW-1:0]         wire_sel,
  input  logic [W-1:0]          wire_idx,
  input  logic [W-1:0]          wire_val,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          in_char,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [W-1:0]          out_char,
  output logic                  out_err,
  output logic [NUM_ROTORS*W-1:0] pos_out
);
  typedef enum logic [1:0] {IDLE, ENC, OUT} state_t;
  state_t state_q, state_d;
  logic [W-1:0] pos_q [NUM_ROTORS];
  logic [W-1:0] pos_d [NUM_ROTORS];
  logic [W-1:0] ring_q [NUM_ROTORS];
  logic [W-1:0] notch_q [NUM_ROTORS];
  logic [W-1:0] sh [NUM_ROTORS];
  logic [W-1:0] fwd_q [NUM_ROTORS][ALPHA];
  logic [W-1:0] bwd_q [NUM_ROTORS][ALPHA];
  logic [W-1:0] refl_q [ALPHA];
`ifdef ROTOR_STACK_PLUGBOARD_EN
  logic [W-1:0] plug_q [ALPHA];
`endif
  logic [W-1:0] char_q, out_char_q, res, c;
  logic         perr_q, out_err_q, accept, wok;

  function automatic logic inr(input logic [W-1:0] x);
    return {1'b0, x} < (W+1)'(ALPHA);
  endfunction
  function automatic logic [W-1:0] madd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s >= (W+1)'(ALPHA) ? W'(s - (W+1)'(ALPHA)) : s[W-1:0];
  endfunction
  function automatic logic [W-1:0] msub(input logic [W-1:0] a, input logic [W-1:0] b);
    return a >= b ? a - b : W'({1'b0, a} + (W+1)'(ALPHA) - {1'b0, b});
  endfunction
  function automatic logic [W-1:0] red(input logic [W-1:0] a);
    return W'({1'b0, a} % (W+1)'(ALPHA));
  endfunction
  function automatic logic [W-1:0] plugmap(input logic [W-1:0] x);
`ifdef ROTOR_STACK_PLUGBOARD_EN
    return plug_q[x];
`else
    return x;
`endif
  endfunction

  assign in_ready  = state_q == IDLE && !load && !wire_we;
  assign accept    = in_valid && in_ready;
  assign out_valid = state_q == OUT;
  assign out_char  = out_char_q;
  assign out_err   = out_err_q;
  assign wok       = wire_we && inr(wire_idx) && inr(wire_val);

  for (genvar i = 0; i < NUM_ROTORS; i++) begin : g_rot
    logic st;
    if (i == 0) begin : g_fast
      assign st = 1'b1;
    end else if (i < NUM_ROTORS - 1) begin : g_mid
      assign st = pos_q[i-1] == notch_q[i-1] || pos_q[i] == notch_q[i];
    end else begin : g_slow
      assign st = pos_q[i-1] == notch_q[i-1];
    end
    assign pos_d[i] = st ? (pos_q[i] == W'(ALPHA - 1) ? '0 : pos_q[i] + 1'b1) : pos_q[i];
    assign sh[i] = msub(pos_q[i], ring_q[i]);
    assign pos_out[i*W +: W] = pos_q[i];
  end

  always_comb begin
    c = plugmap(char_q);
    for (int i = 0; i < NUM_ROTORS; i++) c = msub(fwd_q[i][madd(c, sh[i])], sh[i]);
    c = refl_q[c];
    for (int i = NUM_ROTORS - 1; i >= 0; i--) c = msub(bwd_q[i][madd(c, sh[i])], sh[i]);
    res = plugmap(c);
  end

  always_comb begin
    state_d = load ? IDLE :
              state_q == IDLE ? (accept ? ENC : IDLE) :
              state_q == ENC ? OUT : (out_ready ? IDLE : OUT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_ROTORS; r++)
        for (int k = 0; k < ALPHA; k++) begin
          fwd_q[r][k] <= W'(k);
          bwd_q[r][k] <= W'(k);
        end
      for (int k = 0; k < ALPHA; k++) refl_q[k] <= W'(k);
`ifdef ROTOR_STACK_PLUGBOARD_EN
      for (int k = 0; k < ALPHA; k++) plug_q[k] <= W'(k);
`endif
    end else if (wok) begin
      for (int r = 0; r < NUM_ROTORS; r++)
        if (wire_sel == SW'(r)) begin
          fwd_q[r][wire_idx] <= wire_val;
          bwd_q[r][wire_val] <= wire_idx;
        end
      if (wire_sel == SW'(NUM_ROTORS)) refl_q[wire_idx] <= wire_val;
`ifdef ROTOR_STACK_PLUGBOARD_EN
      if (wire_sel == SW'(NUM_ROTORS + 1)) begin
        plug_q[wire_idx] <= wire_val;
        plug_q[wire_val] <= wire_idx;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      char_q     <= '0;
      perr_q     <= 1'b0;
      out_char_q <= '0;
      out_err_q  <= 1'b0;
      for (int i = 0; i < NUM_ROTORS; i++) begin
        pos_q[i]   <= '0;
        ring_q[i]  <= '0;
        notch_q[i] <= W'(NOTCH_RST);
      end
    end else begin
      state_q <= state_d;
      if (load) begin
        for (int i = 0; i < NUM_ROTORS; i++) begin
          pos_q[i]   <= red(pos_in[i*W +: W]);
          ring_q[i]  <= red(ring_in[i*W +: W]);
          notch_q[i] <= red(notch_in[i*W +: W]);
        end
      end else if (accept && inr(in_char)) begin
        for (int i = 0; i < NUM_ROTORS; i++) pos_q[i] <= pos_d[i];
      end
      if (accept) begin
        char_q <= in_char;
        perr_q <= !inr(in_char);
      end
      if (state_q == ENC && !load) begin
        out_char_q <= perr_q ? char_q : res;
        out_err_q  <= perr_q;
      end
    end
  end
endmodule

// File: tb/tb_rotor_stack_engine.sv
// tb_rotor_stack_engine: directed Enigma I vectors, stepping, backpressure, abort and reset checks.
module tb_rotor_stack_engine;
  localparam int N = 3, A = 26, W = 5, SW = 3;
  logic clk = 0, reset = 1, load = 0, wire_we = 0, in_valid = 0, out_ready = 1;
  logic [N*W-1:0] pos_in = '0, ring_in = '0, notch_in = '0, pos_out;
  logic [SW-1:0] wire_sel = '0;
  logic [W-1:0] wire_idx = '0, wire_val = '0, in_char = '0, out_char;
  logic in_ready, out_valid, out_err;
  int errors = 0, checks = 0;

  rotor_stack_engine dut (
    .clk(clk), .reset(reset), .load(load), .pos_in(pos_in), .ring_in(ring_in),
    .notch_in(notch_in), .wire_we(wire_we), .wire_sel(wire_sel), .wire_idx(wire_idx),
    .wire_val(wire_val), .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
    .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char), .out_err(out_err),
    .pos_out(pos_out)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic wr(input int sel, input int idx, input int val);
    wire_we = 1; wire_sel = SW'(sel); wire_idx = W'(idx); wire_val = W'(val);
    tick;
    wire_we = 0;
  endtask

  task automatic load_table(input int sel, input string s);
    for (int i = 0; i < A; i++) begin
      byte b;
      b = s[i];
      wr(sel, i, int'(b) - 65);
    end
  endtask

  task automatic setup_tables;
    load_table(0, "BDFHJLCPRTXVZNYEIWGAKMUSQO");
    load_table(1, "AJDKSIRUXBLHWTMCQGZNPYFVOE");
    load_table(2, "EKMFLGDQVZNTOWYHXUSPAIBRCJ");
    load_table(3, "YRUHQSLDPXNGOKMIEBFZCWVJAT");
  endtask

  task automatic do_load(input logic [N*W-1:0] p, input logic [N*W-1:0] r);
    load = 1; pos_in = p; ring_in = r; notch_in = {5'd16, 5'd4, 5'd21};
    tick;
    load = 0;
  endtask

  task automatic wait_out;
    int n;
    n = 0;
    while (!out_valid && n < 10) begin
      tick;
      n++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL out_valid_timeout got=0 exp=1");
    end
  endtask

  task automatic send(input logic [W-1:0] ch, output logic [W-1:0] oc, output logic oe);
    in_char = ch; in_valid = 1;
    tick;
    in_valid = 0;
    wait_out;
    oc = out_char; oe = out_err;
    tick;
  endtask

  task automatic test_string(input string name, input string exp);
    logic [W-1:0] oc;
    logic oe;
    for (int i = 0; i < 5; i++) begin
      byte b;
      b = exp[i];
      send(0, oc, oe);
      checks++;
      if (oc !== W'(int'(b) - 65) || oe !== 1'b0) begin
        errors++;
        $display("FAIL %s[%0d] got=%0d err=%0b exp=%0d", name, i, oc, oe, int'(b) - 65);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1; tick; tick; reset = 0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (out_char !== '0) begin errors++; $display("FAIL reset_out_char got=%0d exp=0", out_char); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got=%0b exp=0", out_err); end
    checks++; if (pos_out !== '0) begin errors++; $display("FAIL reset_pos got=%h exp=0", pos_out); end
  endtask

  task automatic test_enigma;
    setup_tables;
    do_load('0, '0);
    test_string("enigma", "BDZGO");
    checks++;
    if (pos_out !== {5'd0, 5'd0, 5'd5}) begin errors++; $display("FAIL enigma_pos got=%h exp=%h", pos_out, {5'd0, 5'd0, 5'd5}); end
  endtask

  task automatic test_double_step;
    logic [N*W-1:0] exp [3];
    logic [W-1:0] oc;
    logic oe;
    exp[0] = {5'd0, 5'd3, 5'd21}; exp[1] = {5'd0, 5'd4, 5'd22}; exp[2] = {5'd1, 5'd5, 5'd23};
    do_load({5'd0, 5'd3, 5'd20}, '0);
    for (int i = 0; i < 3; i++) begin
      send(5'd7, oc, oe);
      checks++;
      if (pos_out !== exp[i]) begin errors++; $display("FAIL double_step[%0d] got=%h exp=%h", i, pos_out, exp[i]); end
    end
  endtask

  task automatic test_ring;
    do_load('0, {5'd1, 5'd1, 5'd1});
    test_string("ring", "EWTYX");
  endtask

  task automatic test_backpressure;
    logic [W-1:0] oc;
    logic oe;
    logic [N*W-1:0] p;
    do_load('0, '0);
    out_ready = 0;
    in_char = 0; in_valid = 1; tick; in_valid = 0;
    wait_out;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_char !== 5'd1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall[%0d] valid=%0b char=%0d ready=%0b exp=1/1/0", i, out_valid, out_char, in_ready);
      end
      tick;
    end
    out_ready = 1; tick;
    p = pos_out;
    checks++;
    if (p !== {5'd0, 5'd0, 5'd1}) begin errors++; $display("FAIL stall_pos got=%h exp=%h", p, {5'd0, 5'd0, 5'd1}); end
    send(5'd30, oc, oe);
    checks++;
    if (oc !== 5'd30 || oe !== 1'b1) begin errors++; $display("FAIL range_err got=%0d/%0b exp=30/1", oc, oe); end
    checks++;
    if (pos_out !== p) begin errors++; $display("FAIL range_pos got=%h exp=%h", pos_out, p); end
  endtask

  task automatic test_abort;
    do_load('0, '0);
    in_char = 0; in_valid = 1; tick; in_valid = 0;
    load = 1; pos_in = {5'd7, 5'd7, 5'd7}; ring_in = '0; notch_in = {5'd16, 5'd4, 5'd21};
    tick;
    load = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_valid1 got=%0b exp=0", out_valid); end
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_valid2 got=%0b exp=0", out_valid); end
    checks++; if (pos_out !== {5'd7, 5'd7, 5'd7}) begin errors++; $display("FAIL abort_pos got=%h exp=%h", pos_out, {5'd7, 5'd7, 5'd7}); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_reset_mid_out;
    out_ready = 0;
    in_char = 3; in_valid = 1; tick; in_valid = 0;
    wait_out;
    reset = 1; tick; reset = 0; out_ready = 1;
    checks++;
    if (out_valid !== 1'b0 || out_char !== '0 || out_err !== 1'b0 || in_ready !== 1'b1 || pos_out !== '0) begin
      errors++;
      $display("FAIL reset_mid_out valid=%0b char=%0d err=%0b ready=%0b pos=%h", out_valid, out_char, out_err, in_ready, pos_out);
    end
  endtask

`ifdef ROTOR_STACK_PLUGBOARD_EN
  task automatic test_plugboard;
    logic [W-1:0] oc;
    logic oe;
    setup_tables;
    wr(N + 1, 0, 1);
    do_load('0, '0);
    send(5'd1, oc, oe);
    checks++;
    if (oc !== 5'd0 || oe !== 1'b0) begin errors++; $display("FAIL plugboard got=%0d/%0b exp=0/0", oc, oe); end
  endtask
`endif

  initial begin
    tick;
    test_reset;
    test_enigma;
    test_double_step;
    test_ring;
    test_backpressure;
    test_abort;
    test_reset_mid_out;
`ifdef ROTOR_STACK_PLUGBOARD_EN
    test_plugboard;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
